// File: rtl/eco_sweep_pkg.sv
// ---------------------------------------------------------------------------
// eco_sweep_pkg
// Shared definitions for the ECO equivalence sweeper:
//   state_t      - sequencer states (IDLE, RUN, DRAIN, DONE)
//   LAT_MAX      - deepest cone latency the delay line is meant to cover
//   DRAIN_CNT_W  - width of the drain cycle counter (enough for LAT_MAX)
//   cnt_width()  - width of the mismatch counter for a given input width.
//                  It is one bit wider than the vector so it can hold the
//                  full 2^N_IN count without saturating.
// ---------------------------------------------------------------------------
package eco_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int LAT_MAX     = 7;
  localparam int DRAIN_CNT_W = 3;

  function automatic int cnt_width(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/eco_vec_delay.sv
// ---------------------------------------------------------------------------
// eco_vec_delay
// Shift register carrying {valid, vec} alongside the cone pipeline so that
// the tag leaving the last stage lines up with the cone outputs it belongs
// to. DEPTH=0 turns the block into a plain pass-through.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low clear of every stage
//   flush     in   synchronous kill of all valid bits (vectors in flight are
//                  dropped without being compared)
//   in_valid  in   valid bit of the vector currently driven to the cones
//   in_vec    in   W-bit vector currently driven to the cones
//   out_valid out  tag valid, aligned with the cone outputs
//   out_vec   out  tag vector, aligned with the cone outputs
// ---------------------------------------------------------------------------
module eco_vec_delay #(
  parameter int W     = 16,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_vec,
  output logic         out_valid,
  output logic [W-1:0] out_vec
);

  // At least one stage is always declared so the array stays legal when
  // DEPTH=0; in that case the stage is simply never selected.
  localparam int SD = (DEPTH == 0) ? 1 : DEPTH;

  logic [SD-1:0]        valid_q;
  logic [SD-1:0][W-1:0] vec_q;

  // Stage 0 takes the live vector; every later stage takes its neighbour.
  // A flush clears the valid bits on the way in, so anything in flight is
  // forgotten on the next edge while the vector payload just keeps moving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      vec_q   <= '0;
    end else begin
      valid_q[0] <= in_valid & ~flush;
      vec_q[0]   <= in_vec;
      for (int i = 1; i < SD; i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush;
        vec_q[i]   <= vec_q[i-1];
      end
    end
  end

  assign out_valid = (DEPTH == 0) ? in_valid : valid_q[SD-1];
  assign out_vec   = (DEPTH == 0) ? in_vec   : vec_q[SD-1];

endmodule

// File: rtl/eco_equiv_sweeper.sv
// ---------------------------------------------------------------------------
// eco_equiv_sweeper
// Walks every N_IN-bit input vector through a golden and a revised cone,
// compares their single-bit outputs LAT cycles later and reports whether
// the patched cone is equivalent, how many vectors disagree and the first
// vector that disagreed.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   start         in   pulse, starts a sweep from IDLE or DONE
//   abort         in   pulse, cancels the sweep (wins over everything)
//   stop_on_fail  in   sampled at start, end the sweep at the first mismatch
//   vec_o         out  registered vector driven to both cones
//   vec_valid_o   out  vec_o carries an issued vector this cycle
//   gold_i        in   golden cone output
//   rev_i         in   revised cone output
//   busy          out  sweep in progress (RUN or DRAIN)
//   done          out  sweep finished, held until the next start
//   fail          out  sticky, at least one mismatch this sweep
//   fail_vec      out  first mismatching vector
//   mismatch_cnt  out  number of mismatching vectors (never saturates)
// ---------------------------------------------------------------------------
module eco_equiv_sweeper
  import eco_sweep_pkg::*;
#(
  parameter int N_IN = 16,
  parameter int LAT  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       stop_on_fail,
  output logic [N_IN-1:0]            vec_o,
  output logic                       vec_valid_o,
  input  logic                       gold_i,
  input  logic                       rev_i,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic [N_IN-1:0]            fail_vec,
  output logic [cnt_width(N_IN)-1:0] mismatch_cnt
);

  localparam int CW = cnt_width(N_IN);

  // LAT is expected to stay within 0..LAT_MAX; the drain counter is sized
  // for that range. DRAIN lasts LAT cycles, so its final count is LAT-1.
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST =
    DRAIN_CNT_W'((LAT > 0) ? LAT - 1 : 0);

  state_t                 state;
  state_t                 next_state;
  logic [N_IN-1:0]        counter;
  logic                   issued_last;
  logic                   stop_latched;
  logic [DRAIN_CNT_W-1:0] drain_cnt;

  logic                   tag_valid;
  logic [N_IN-1:0]        tag_vec;
  logic                   mismatch;
  logic                   stop_hit;
  logic                   launch;
  logic                   issue;
  logic                   flush;

  // A mismatch only counts when the delay line says the cone outputs belong
  // to an issued vector; outside that window the cones may toggle freely.
  assign mismatch = tag_valid && (gold_i != rev_i);
  assign stop_hit = stop_latched && mismatch;

  // A new sweep may only begin from IDLE or DONE, and never alongside abort.
  assign launch = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));

  // Issue a vector only while RUN continues into another RUN cycle; a stop
  // or abort on this edge therefore issues nothing and drops vec_valid_o.
  assign issue = (state == ST_RUN) && !issued_last && (next_state == ST_RUN);

  // Whenever the sweep is left (abort, stop, normal completion) anything
  // still travelling through the delay line is discarded uncompared.
  assign flush = (next_state != ST_RUN) && (next_state != ST_DRAIN);

  eco_vec_delay #(
    .W     (N_IN),
    .DEPTH (LAT)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (vec_valid_o),
    .in_vec    (vec_o),
    .out_valid (tag_valid),
    .out_vec   (tag_vec)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. RUN keeps going until the all-ones vector has been
  // issued and shown to the cones for one cycle; with LAT=0 that cycle is
  // also its compare, so RUN goes straight to DONE, otherwise DRAIN waits
  // LAT more cycles for the last vector to reach the compare stage.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) next_state = ST_RUN;
        end
        ST_RUN: begin
          if (stop_hit) begin
            next_state = ST_DONE;
          end else if (issued_last) begin
            next_state = (LAT == 0) ? ST_DONE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (stop_hit || (drain_cnt == DRAIN_LAST)) next_state = ST_DONE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded straight from the registered state.
  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

  // Vector counter and issue register. The end of the sweep is found by
  // comparing against all-ones when issuing, so the counter simply wraps
  // afterwards and no overflow bit is needed. vec_o keeps its last value
  // whenever nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter      <= '0;
      issued_last  <= 1'b0;
      stop_latched <= 1'b0;
      vec_o        <= '0;
      vec_valid_o  <= 1'b0;
    end else begin
      vec_valid_o <= issue;
      if (launch) begin
        counter      <= '0;
        issued_last  <= 1'b0;
        stop_latched <= stop_on_fail;
      end else if (issue) begin
        vec_o   <= counter;
        counter <= counter + 1'b1;
        if (counter == {N_IN{1'b1}}) issued_last <= 1'b1;
      end
    end
  end

  // Drain cycle counter, restarted every time DRAIN is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state == ST_DRAIN) begin
      drain_cnt <= drain_cnt + 1'b1;
    end else begin
      drain_cnt <= '0;
    end
  end

  // Result capture. A start clears the previous sweep's results; an abort
  // freezes them exactly as they were, including any compare that happens
  // to coincide with the abort edge. Only the first mismatch of a sweep
  // records its vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail         <= 1'b0;
      fail_vec     <= '0;
      mismatch_cnt <= '0;
    end else if (launch) begin
      fail         <= 1'b0;
      fail_vec     <= '0;
      mismatch_cnt <= '0;
    end else if (mismatch && !abort) begin
      mismatch_cnt <= mismatch_cnt + CW'(1);
      if (!fail) fail_vec <= tag_vec;
      fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eco_equiv_sweeper.sv
// ---------------------------------------------------------------------------
// tb_eco_equiv_sweeper
// Two sweeper instances share one clock: "a" is N_IN=4 / LAT=2 with a two
// stage registered cone model, "b" is the full N_IN=16 / LAT=0 build with
// purely combinational cones. Every tracked sweep pushes its hand-computed
// result (done edge, fail, fail_vec, mismatch count) into a queue; monitors
// pop and compare when done rises and also check the issued vector stream.
// ---------------------------------------------------------------------------
module tb_eco_equiv_sweeper;

  typedef struct {
    int          done_cyc;
    logic        fail;
    logic [15:0] fv;
    int          cnt;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // Instance a: N_IN=4, LAT=2.
  logic        rst_n_a = 1'b0;
  logic        start_a = 1'b0;
  logic        abort_a = 1'b0;
  logic        stop_a = 1'b0;
  logic [3:0]  vec_a;
  logic        vv_a;
  logic        gold_a;
  logic        rev_a;
  logic        busy_a;
  logic        done_a;
  logic        fail_a;
  logic [3:0]  fv_a;
  logic [4:0]  cnt_a;
  logic        fault_en_a = 1'b0;
  logic [3:0]  cone_d1 = 4'd0;
  logic [3:0]  cone_d2 = 4'd0;

  // Instance b: N_IN=16, LAT=0.
  logic        rst_n_b = 1'b0;
  logic        start_b = 1'b0;
  logic        abort_b = 1'b0;
  logic        stop_b = 1'b0;
  logic [15:0] vec_b;
  logic        vv_b;
  logic        gold_b;
  logic        rev_b;
  logic        busy_b;
  logic        done_b;
  logic        fail_b;
  logic [15:0] fv_b;
  logic [16:0] cnt_b;
  logic        fault_en_b = 1'b0;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  exp_t        e_a;
  exp_t        e_b;
  logic [3:0]  exp_next_a = 4'd0;
  logic [15:0] exp_next_b = 16'd0;
  logic        done_q_a = 1'b0;
  logic        busy_q_a = 1'b0;
  logic        done_q_b = 1'b0;
  logic        busy_q_b = 1'b0;

  eco_equiv_sweeper #(.N_IN(4), .LAT(2)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n_a),
    .start        (start_a),
    .abort        (abort_a),
    .stop_on_fail (stop_a),
    .vec_o        (vec_a),
    .vec_valid_o  (vv_a),
    .gold_i       (gold_a),
    .rev_i        (rev_a),
    .busy         (busy_a),
    .done         (done_a),
    .fail         (fail_a),
    .fail_vec     (fv_a),
    .mismatch_cnt (cnt_a)
  );

  eco_equiv_sweeper #(.N_IN(16), .LAT(0)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n_b),
    .start        (start_b),
    .abort        (abort_b),
    .stop_on_fail (stop_b),
    .vec_o        (vec_b),
    .vec_valid_o  (vv_b),
    .gold_i       (gold_b),
    .rev_i        (rev_b),
    .busy         (busy_b),
    .done         (done_b),
    .fail         (fail_b),
    .fail_vec     (fv_b),
    .mismatch_cnt (cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cone model for a: two register stages, gold = xor-reduce, rev flips
  // at vectors 5 and 11 when the fault is enabled.
  always @(posedge clk) begin
    cone_d1 <= vec_a;
    cone_d2 <= cone_d1;
  end
  assign gold_a = ^cone_d2;
  assign rev_a  = (^cone_d2) ^ (fault_en_a && (cone_d2 == 4'd5 || cone_d2 == 4'd11));

  // Cone model for b: combinational, rev flips only at the last vector.
  assign gold_b = ^vec_b;
  assign rev_b  = (^vec_b) ^ (fault_en_b && (vec_b == 16'hFFFF));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, act, req);
    end
  endtask

  // Starts a sweep. fresh: a launch is expected, so the vector stream
  // restarts at 0. track: push the expected end-of-sweep result.
  task automatic applyStimulus(input bit inst_b, input bit stop, input bit fresh,
                               input bit track, input int lat, input bit f,
                               input logic [15:0] fv, input int cnt);
    exp_t e;
    @(posedge clk); #1;
    if (inst_b) begin
      stop_b  = stop;
      start_b = 1'b1;
      if (fresh) exp_next_b = 16'd0;
    end else begin
      stop_a  = stop;
      start_a = 1'b1;
      if (fresh) exp_next_a = 4'd0;
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (track) begin
      e.done_cyc = cyc + lat;
      e.fail     = f;
      e.fv       = fv;
      e.cnt      = cnt;
      if (inst_b) sb_b.push_back(e);
      else        sb_a.push_back(e);
    end
  endtask

  task automatic waitDone(input bit inst_b, input int limit);
    int n = 0;
    while (n < limit && !(inst_b ? done_b : done_a)) begin
      @(negedge clk);
      n++;
    end
    checkOutput(inst_b ? "done_b_seen" : "done_a_seen",
                {31'd0, (inst_b ? done_b : done_a)}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Monitor for a: vector stream and end-of-sweep scoreboard.
  always @(negedge clk) begin
    if (rst_n_a) begin
      if (vv_a) begin
        checkOutput("vec_a", {28'd0, vec_a}, {28'd0, exp_next_a});
        exp_next_a = exp_next_a + 4'd1;
      end
      if (done_a && !done_q_a) begin
        if (sb_a.size() == 0) begin
          checkOutput("a_unexpected_done", 32'd1, 32'd0);
        end else begin
          e_a = sb_a.pop_front();
          checkOutput("a_done_edge", cyc, e_a.done_cyc);
          checkOutput("a_fail", {31'd0, fail_a}, {31'd0, e_a.fail});
          checkOutput("a_fail_vec", {28'd0, fv_a}, {16'd0, e_a.fv});
          checkOutput("a_mismatch_cnt", {27'd0, cnt_a}, e_a.cnt);
          checkOutput("a_busy_falls", {31'd0, busy_a}, 32'd0);
          checkOutput("a_busy_before_done", {31'd0, busy_q_a}, 32'd1);
        end
      end
    end
    done_q_a = done_a;
    busy_q_a = busy_a;
  end

  // Monitor for b.
  always @(negedge clk) begin
    if (rst_n_b) begin
      if (vv_b) begin
        checkOutput("vec_b", {16'd0, vec_b}, {16'd0, exp_next_b});
        exp_next_b = exp_next_b + 16'd1;
      end
      if (done_b && !done_q_b) begin
        if (sb_b.size() == 0) begin
          checkOutput("b_unexpected_done", 32'd1, 32'd0);
        end else begin
          e_b = sb_b.pop_front();
          checkOutput("b_done_edge", cyc, e_b.done_cyc);
          checkOutput("b_fail", {31'd0, fail_b}, {31'd0, e_b.fail});
          checkOutput("b_fail_vec", {16'd0, fv_b}, {16'd0, e_b.fv});
          checkOutput("b_mismatch_cnt", {15'd0, cnt_b}, e_b.cnt);
          checkOutput("b_busy_falls", {31'd0, busy_b}, 32'd0);
          checkOutput("b_busy_before_done", {31'd0, busy_q_b}, 32'd1);
        end
      end
    end
    done_q_b = done_b;
    busy_q_b = busy_b;
  end

  initial begin
    int n;
    $display("[TB] starting eco_equiv_sweeper bench");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(posedge clk); #1;

    // Reset state.
    checkOutput("rst_a_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rst_a_done", {31'd0, done_a}, 32'd0);
    checkOutput("rst_a_fail", {31'd0, fail_a}, 32'd0);
    checkOutput("rst_a_cnt", {27'd0, cnt_a}, 32'd0);
    checkOutput("rst_a_vv", {31'd0, vv_a}, 32'd0);
    checkOutput("rst_a_vec", {28'd0, vec_a}, 32'd0);
    checkOutput("rst_b_busy", {31'd0, busy_b}, 32'd0);
    checkOutput("rst_b_done", {31'd0, done_b}, 32'd0);

    // Equivalent cones: done 19 edges after start, clean result.
    fault_en_a = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 19, 1'b0, 16'd0, 0);
    waitDone(1'b0, 40);

    // Mismatches at 5 and 11, run to the end.
    fault_en_a = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 19, 1'b1, 16'd5, 2);
    waitDone(1'b0, 40);

    // Stop on fail: vec 5 reaches the compare stage in the cycle after
    // edge 8, so DONE is entered on edge 9 with only one mismatch counted.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 9, 1'b1, 16'd5, 1);
    waitDone(1'b0, 40);

    // Abort in DONE: back to IDLE, results hold.
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    checkOutput("abort_done_done", {31'd0, done_a}, 32'd0);
    checkOutput("abort_done_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("abort_hold_fail", {31'd0, fail_a}, 32'd1);
    checkOutput("abort_hold_fv", {28'd0, fv_a}, 32'd5);
    checkOutput("abort_hold_cnt", {27'd0, cnt_a}, 32'd1);

    // Abort mid-sweep when vec_o shows 7.
    fault_en_a = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 16'd0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(vv_a && vec_a == 4'd7) && n < 40);
    checkOutput("abort_reach_vec7", {28'd0, vec_a}, 32'd7);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    checkOutput("abort_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("abort_done", {31'd0, done_a}, 32'd0);
    checkOutput("abort_vv", {31'd0, vv_a}, 32'd0);

    // Restart after abort must begin again at vector 0.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 19, 1'b0, 16'd0, 0);
    waitDone(1'b0, 40);

    // Asynchronous reset mid-sweep, applied between clock edges.
    fault_en_a = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 16'd0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(vv_a && vec_a == 4'd12) && n < 40);
    checkOutput("pre_rst_fail", {31'd0, fail_a}, 32'd1);
    rst_n_a = 1'b0;
    #1;
    checkOutput("arst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("arst_done", {31'd0, done_a}, 32'd0);
    checkOutput("arst_fail", {31'd0, fail_a}, 32'd0);
    checkOutput("arst_fv", {28'd0, fv_a}, 32'd0);
    checkOutput("arst_cnt", {27'd0, cnt_a}, 32'd0);
    checkOutput("arst_vv", {31'd0, vv_a}, 32'd0);
    checkOutput("arst_vec", {28'd0, vec_a}, 32'd0);
    #2;
    rst_n_a = 1'b1;
    @(posedge clk); #1;

    // start and abort together from IDLE: abort wins.
    start_a = 1'b1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    abort_a = 1'b0;
    checkOutput("collide_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("collide_done", {31'd0, done_a}, 32'd0);
    checkOutput("collide_vv", {31'd0, vv_a}, 32'd0);
    @(posedge clk); #1;
    checkOutput("collide_busy_later", {31'd0, busy_a}, 32'd0);

    // start while busy is ignored: timing and vector stream continue.
    fault_en_a = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 19, 1'b0, 16'd0, 0);
    repeat (4) @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    checkOutput("busy_restart_try", {31'd0, busy_a}, 32'd1);
    waitDone(1'b0, 40);

    // Full-width LAT=0 sweep with a fault only at the last vector.
    fault_en_b = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 65537, 1'b1, 16'hFFFF, 1);
    waitDone(1'b1, 70000);

    checkOutput("sb_a_drained", sb_a.size(), 32'd0);
    checkOutput("sb_b_drained", sb_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
